// File: rtl/veer_types.sv
// Shared types and constants for the IFU branch-predictor update path.
package veer_types;

  localparam int BHT_ADDR_W_DEF = 8;

  typedef enum logic {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [BHT_ADDR_W_DEF-1:0] index;
    logic [1:0]                hist;
    logic                      misp;
  } bp_upd_pkt_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ifu_bp_upd_fifo.sv
// Circular update queue keyed by BHT index, with a youngest-match lookup port.
module ifu_bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int KW    = 8,
  parameter int DW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [KW-1:0]           push_key,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  output logic [KW-1:0]           head_key,
  output logic [DW-1:0]           head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [KW-1:0]           lkp_key,
  output logic                    lkp_hit,
  output logic [DW-1:0]           lkp_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [KW-1:0]    key_q  [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] match;
  logic [DW-1:0]    age_data [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      key_q[wr_ptr_q]  <= push_key;
      data_q[wr_ptr_q] <= push_data;
    end
  end

  // Slot gi holds the gi-th oldest entry; higher gi is younger.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
    logic [PW-1:0] slot;
    assign slot          = rd_ptr_q + PW'(gi);
    assign match[gi]     = (CW'(gi) < count_q) && (key_q[slot] == lkp_key);
    assign age_data[gi]  = data_q[slot];
  end

  always_comb begin
    lkp_hit  = 1'b0;
    lkp_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) begin
        lkp_hit  = 1'b1;
        lkp_data = age_data[i];
      end
    end
  end

  assign head_key  = key_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/ifu_bp_upd_ctl.sv
// BHT update controller: clears the table, queues EXU updates, arbitrates the single table port.
// Optional youngest-queued-entry read bypass under BP_UPD_BYPASS_EN.
module ifu_bp_upd_ctl
  import veer_types::*;
#(
  parameter int BHT_ADDR_W = BHT_ADDR_W_DEF,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_upd_valid,
  input  logic [BHT_ADDR_W-1:0] exu_upd_index,
  input  logic [1:0]            exu_upd_hist,
  input  logic                  exu_upd_misp,
  output logic                  exu_upd_ready,
  input  logic                  ifu_rd_valid,
  input  logic [BHT_ADDR_W-1:0] ifu_rd_index,
  output logic                  ifu_rd_hist_valid,
  output logic [1:0]            ifu_rd_hist,
  output logic [7:0]            bp_drop_cnt,
  output logic [15:0]           bp_misp_cnt
);
  localparam int ENTRIES = 2 ** BHT_ADDR_W;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int SW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  bp_state_e             state_q, state_d;
  logic [BHT_ADDR_W-1:0] init_ptr_q, init_ptr_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [1:0]            bht_q [ENTRIES];
  logic                  rd_valid_q;
  logic [1:0]            ram_rd_q;
  logic [7:0]            drop_q;
  logic [15:0]           misp_q;

  logic                  run, upd_accept, head_wr, rd_fire;
  logic                  tbl_we;
  logic [BHT_ADDR_W-1:0] tbl_wa;
  logic [1:0]            tbl_wd, rd_hist_sel;
  logic [BHT_ADDR_W-1:0] head_key;
  logic [1:0]            head_data, lkp_data;
  logic                  fifo_full, fifo_empty, lkp_hit;
  logic [CW-1:0]         fifo_count;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      BP_INIT: begin
        init_ptr_d = init_ptr_q + BHT_ADDR_W'(1);
        if (init_ptr_q == '1) state_d = BP_RUN;
      end
      default: ;
    endcase
  end

  assign run           = (state_q == BP_RUN);
  assign exu_upd_ready = run && (fifo_count < CW'(DEPTH));
  assign upd_accept    = exu_upd_valid & exu_upd_ready;
  // Reads win until the queue has been blocked STARVE_MAX cycles in a row.
  assign head_wr       = run & ~fifo_empty & (~ifu_rd_valid | (starve_q == SW'(STARVE_MAX)));
  assign rd_fire       = run & ifu_rd_valid & ~head_wr;

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || head_wr) starve_d = '0;
    else if (rd_fire)          starve_d = starve_q + SW'(1);
  end

  assign tbl_we = ~run | head_wr;
  assign tbl_wa = run ? head_key  : init_ptr_q;
  assign tbl_wd = run ? head_data : 2'b00;

  always_ff @(posedge clk) begin
    if (tbl_we)  bht_q[tbl_wa] <= tbl_wd;
    if (rd_fire) ram_rd_q      <= bht_q[ifu_rd_index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BP_INIT;
      init_ptr_q <= '0;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= '0;
      misp_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_fire;
      if (exu_upd_valid && !exu_upd_ready) drop_q <= sat_inc8(drop_q);
      if (upd_accept && exu_upd_misp)      misp_q <= misp_q + 16'd1;
    end
  end

  ifu_bp_upd_fifo #(
    .DEPTH (DEPTH),
    .KW    (BHT_ADDR_W),
    .DW    (2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (upd_accept),
    .push_key  (exu_upd_index),
    .push_data (exu_upd_hist),
    .pop       (head_wr),
    .head_key  (head_key),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .lkp_key   (ifu_rd_index),
    .lkp_hit   (lkp_hit),
    .lkp_data  (lkp_data)
  );

`ifdef BP_UPD_BYPASS_EN
  logic       byp_hit_q;
  logic [1:0] byp_hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit_q  <= 1'b0;
      byp_hist_q <= 2'b00;
    end else if (rd_fire) begin
      byp_hit_q  <= lkp_hit;
      byp_hist_q <= lkp_data;
    end
  end

  assign rd_hist_sel = byp_hit_q ? byp_hist_q : ram_rd_q;

  logic unused_sig;
  assign unused_sig = fifo_full;
`else
  assign rd_hist_sel = ram_rd_q;

  logic unused_sig;
  assign unused_sig = ^{fifo_full, lkp_hit, lkp_data};
`endif

  assign ifu_rd_hist_valid = rd_valid_q;
  assign ifu_rd_hist       = rd_valid_q ? rd_hist_sel : 2'b00;
  assign bp_drop_cnt       = drop_q;
  assign bp_misp_cnt       = misp_q;

endmodule

// File: tb/tb_ifu_bp_upd_ctl.sv
// Directed, table-driven bench for ifu_bp_upd_ctl (expectations follow BP_UPD_BYPASS_EN when defined).
module tb_ifu_bp_upd_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_upd_valid;
  logic [7:0]  exu_upd_index;
  logic [1:0]  exu_upd_hist;
  logic        exu_upd_misp;
  logic        exu_upd_ready;
  logic        ifu_rd_valid;
  logic [7:0]  ifu_rd_index;
  logic        ifu_rd_hist_valid;
  logic [1:0]  ifu_rd_hist;
  logic [7:0]  bp_drop_cnt;
  logic [15:0] bp_misp_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifu_bp_upd_ctl dut (
    .clk               (clk),
    .rst               (rst),
    .exu_upd_valid     (exu_upd_valid),
    .exu_upd_index     (exu_upd_index),
    .exu_upd_hist      (exu_upd_hist),
    .exu_upd_misp      (exu_upd_misp),
    .exu_upd_ready     (exu_upd_ready),
    .ifu_rd_valid      (ifu_rd_valid),
    .ifu_rd_index      (ifu_rd_index),
    .ifu_rd_hist_valid (ifu_rd_hist_valid),
    .ifu_rd_hist       (ifu_rd_hist),
    .bp_drop_cnt       (bp_drop_cnt),
    .bp_misp_cnt       (bp_misp_cnt)
  );

  typedef struct {
    logic [7:0] uidx;
    logic [1:0] uhist;
    logic [7:0] ridx;
    logic [1:0] exp_hist;
  } vec_t;

  typedef struct {
    logic [1:0] hist;
    logic       misp;
    logic       exp_rdy;
  } bvec_t;

  vec_t  vecs [7];
  bvec_t bvs  [7];
  int    starve_exp [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end else begin
      $display("ok   %s value=%0h", nm, act);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] idx, input logic [1:0] exp);
    ifu_rd_valid = 1'b1;
    ifu_rd_index = idx;
    tick();
    ifu_rd_valid = 1'b0;
    chk({nm, "_valid"}, 32'(ifu_rd_hist_valid), 32'd1);
    chk({nm, "_hist"},  32'(ifu_rd_hist), 32'(exp));
  endtask

  // Counts INIT cycles while issuing reads, which must stay invisible.
  task automatic wait_init(input string nm);
    int   n;
    logic leak;
    n    = 0;
    leak = 1'b0;
    ifu_rd_valid = 1'b1;
    ifu_rd_index = 8'h3F;
    while (!exu_upd_ready && n < 400) begin
      tick();
      n++;
      if (ifu_rd_hist_valid || ifu_rd_hist != 2'b00) leak = 1'b1;
    end
    ifu_rd_valid = 1'b0;
    chk({nm, "_init_len"}, 32'(n), 32'd256);
    chk({nm, "_init_rd_quiet"}, 32'(leak), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'h10, 2'd3, 8'h10, 2'd3};
    vecs[1] = '{8'h20, 2'd1, 8'h20, 2'd1};
    vecs[2] = '{8'h10, 2'd2, 8'h10, 2'd2};
    vecs[3] = '{8'hFF, 2'd3, 8'hFF, 2'd3};
    vecs[4] = '{8'h00, 2'd1, 8'h00, 2'd1};
    vecs[5] = '{8'h05, 2'd2, 8'h06, 2'd0};
    vecs[6] = '{8'h20, 2'd0, 8'h20, 2'd0};

    // Read-every-cycle burst to one index: queue fills after 4, head drains on the 4th blocked cycle.
    bvs[0] = '{2'd1, 1'b1, 1'b1};
    bvs[1] = '{2'd2, 1'b0, 1'b1};
    bvs[2] = '{2'd3, 1'b1, 1'b1};
    bvs[3] = '{2'd1, 1'b0, 1'b1};
    bvs[4] = '{2'd2, 1'b1, 1'b0};
    bvs[5] = '{2'd3, 1'b1, 1'b1};
    bvs[6] = '{2'd0, 1'b1, 1'b0};

    starve_exp[0] = 1; starve_exp[1] = 1; starve_exp[2] = 1;
    starve_exp[3] = 1; starve_exp[4] = 0; starve_exp[5] = 1;

    rst = 1'b1;
    exu_upd_valid = 1'b0; exu_upd_index = '0; exu_upd_hist = '0; exu_upd_misp = 1'b0;
    ifu_rd_valid = 1'b0;  ifu_rd_index = '0;
    tick(); tick();
    chk("rst_ready", 32'(exu_upd_ready), 32'd0);
    chk("rst_rd_valid", 32'(ifu_rd_hist_valid), 32'd0);
    chk("rst_rd_hist", 32'(ifu_rd_hist), 32'd0);
    chk("rst_drop", 32'(bp_drop_cnt), 32'd0);
    chk("rst_misp", 32'(bp_misp_cnt), 32'd0);
    rst = 1'b0;

    wait_init("boot");
    rd_chk("clear_3f", 8'h3F, 2'd0);

    // Update then drain with no reads; read two cycles after enqueue.
    for (int i = 0; i < 7; i++) begin
      exu_upd_valid = 1'b1;
      exu_upd_index = vecs[i].uidx;
      exu_upd_hist  = vecs[i].uhist;
      chk($sformatf("vec%0d_ready", i), 32'(exu_upd_ready), 32'd1);
      tick();
      exu_upd_valid = 1'b0;
      tick();
      rd_chk($sformatf("vec%0d", i), vecs[i].ridx, vecs[i].exp_hist);
    end

    // One queued update under continuous reads: write wins after 3 blocked cycles.
    exu_upd_valid = 1'b1; exu_upd_index = 8'h41; exu_upd_hist = 2'd2;
    ifu_rd_valid  = 1'b1; ifu_rd_index  = 8'h40;
    for (int i = 0; i < 6; i++) begin
      tick();
      exu_upd_valid = 1'b0;
      chk($sformatf("starve_c%0d_valid", i), 32'(ifu_rd_hist_valid), 32'(starve_exp[i]));
    end
    ifu_rd_valid = 1'b0;
    rd_chk("starve_written", 8'h41, 2'd2);

    // Burst of 7 updates to 0x50 with reads every cycle.
    ifu_rd_valid = 1'b1; ifu_rd_index = 8'h70;
    for (int i = 0; i < 7; i++) begin
      exu_upd_valid = 1'b1;
      exu_upd_index = 8'h50;
      exu_upd_hist  = bvs[i].hist;
      exu_upd_misp  = bvs[i].misp;
      chk($sformatf("burst%0d_ready", i), 32'(exu_upd_ready), 32'(bvs[i].exp_rdy));
      tick();
    end
    exu_upd_valid = 1'b0; exu_upd_misp = 1'b0; ifu_rd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("burst_drop", 32'(bp_drop_cnt), 32'd2);
    chk("burst_misp", 32'(bp_misp_cnt), 32'd3);
    rd_chk("burst_last_wins", 8'h50, 2'd3);

    // Long overload: drop counter must saturate.
    ifu_rd_valid = 1'b1; ifu_rd_index = 8'h61;
    exu_upd_valid = 1'b1; exu_upd_index = 8'h60; exu_upd_hist = 2'd1;
    for (int i = 0; i < 400; i++) tick();
    exu_upd_valid = 1'b0; ifu_rd_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("drop_saturate", 32'(bp_drop_cnt), 32'd255);
    chk("misp_hold", 32'(bp_misp_cnt), 32'd3);

    // Two queued updates to 0x22, read before either drains.
    exu_upd_valid = 1'b1; exu_upd_index = 8'h22; exu_upd_hist = 2'd1;
    ifu_rd_valid  = 1'b1; ifu_rd_index  = 8'h00;
    tick();
    exu_upd_hist = 2'd2; ifu_rd_index = 8'h01;
    tick();
    exu_upd_valid = 1'b0; ifu_rd_index = 8'h22;
    tick();
    ifu_rd_valid = 1'b0;
    chk("bypass_valid", 32'(ifu_rd_hist_valid), 32'd1);
`ifdef BP_UPD_BYPASS_EN
    chk("bypass_hist", 32'(ifu_rd_hist), 32'd2);
`else
    chk("bypass_hist", 32'(ifu_rd_hist), 32'd0);
`endif
    for (int i = 0; i < 4; i++) tick();
    rd_chk("bypass_drained", 8'h22, 2'd2);

    // Reset mid-RUN with 3 queued updates.
    ifu_rd_valid = 1'b1; ifu_rd_index = 8'h00;
    exu_upd_valid = 1'b1; exu_upd_hist = 2'd3;
    for (int i = 0; i < 3; i++) begin
      exu_upd_index = 8'h30 + 8'(i);
      tick();
    end
    exu_upd_valid = 1'b0; ifu_rd_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst2_ready", 32'(exu_upd_ready), 32'd0);
    chk("rst2_rd_valid", 32'(ifu_rd_hist_valid), 32'd0);
    chk("rst2_drop", 32'(bp_drop_cnt), 32'd0);
    chk("rst2_misp", 32'(bp_misp_cnt), 32'd0);
    rst = 1'b0;
    wait_init("reboot");
    rd_chk("rst2_queued_lost", 8'h30, 2'd0);
    rd_chk("rst2_recleared_10", 8'h10, 2'd0);
    rd_chk("rst2_recleared_50", 8'h50, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
